// File: rtl/sm4_pkg.sv
// SM4 key schedule shared constants and state type.
package sm4_pkg;

   localparam int ROUNDS = 32;

   localparam logic [31:0] FK0 = 32'ha3b1bac6;
   localparam logic [31:0] FK1 = 32'h56aa3350;
   localparam logic [31:0] FK2 = 32'h677d9197;
   localparam logic [31:0] FK3 = 32'hb27022dc;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      ROUND,
      DONE
   } state_t;

endpackage

// File: rtl/sm4_rk_regfile.sv
// 32x32 round-key store, one write port, order-mapped read port.
// SM4_KEY_DEC_ORDER_EN adds rd_rev for reversed (decryption) reads.
module sm4_rk_regfile
   import sm4_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr,
`ifdef SM4_KEY_DEC_ORDER_EN
   input  logic        rd_rev,
`endif
   output logic [31:0] rdata
);

   logic [31:0] mem [ROUNDS];
   logic [4:0]  ra;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ROUNDS; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

`ifdef SM4_KEY_DEC_ORDER_EN
   assign ra = rd_rev ? 5'd31 - raddr : raddr;
`else
   assign ra = raddr;
`endif

   assign rdata = mem[ra];

endmodule

// File: rtl/sm4_key_sched.sv
// SM4 key expansion: 32 rounds, external CK ROM and T' unit.
// SM4_KEY_DEC_ORDER_EN adds rk_dec for reversed round-key reads.
module sm4_key_sched
   import sm4_pkg::*;
#(
   parameter int ROM_LAT = 1
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] mk,
   output logic [4:0]   ck_count,
   input  logic [31:0]  ck_data,
   output logic [31:0]  t_in,
   input  logic [31:0]  t_out,
   output logic         busy,
   output logic         done,
   output logic         key_valid,
   input  logic [4:0]   rk_rd_addr,
`ifdef SM4_KEY_DEC_ORDER_EN
   input  logic         rk_dec,
`endif
   output logic [31:0]  rk_rd_data
);

   localparam logic [4:0] PRIME_END = 5'(ROM_LAT - 1);

   state_t      state, state_nx;
   logic [31:0] k0, k1, k2, k3;
   logic [31:0] rk, rd_raw;
   logic [4:0]  rnd, ck_idx;
   logic        kv_q;
   logic        accept, in_round;
   logic        last_prime, last_round;

   assign accept     = (state == IDLE) && start;
   assign in_round   = (state == ROUND);
   assign last_prime = (ck_idx == PRIME_END);
   assign last_round = (rnd == 5'd31);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = PRIME;
         PRIME:   if (last_prime) state_nx = ROUND;
         ROUND:   if (last_round) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy     = (state == PRIME) || in_round;
   assign done     = (state == DONE);
   assign ck_count = busy ? ck_idx : '0;
   assign t_in     = in_round ? (k1 ^ k2 ^ k3 ^ ck_data) : '0;
   assign rk       = k0 ^ t_out;

   // a fresh request invalidates the old schedule in its own cycle
   assign key_valid = kv_q && !accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         k0     <= '0;
         k1     <= '0;
         k2     <= '0;
         k3     <= '0;
         rnd    <= '0;
         ck_idx <= '0;
         kv_q   <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            k0     <= mk[127:96] ^ FK0;
            k1     <= mk[95:64]  ^ FK1;
            k2     <= mk[63:32]  ^ FK2;
            k3     <= mk[31:0]   ^ FK3;
            rnd    <= '0;
            ck_idx <= '0;
            kv_q   <= 1'b0;
         end
         if (busy) ck_idx <= ck_idx + 5'd1;
         if (in_round) begin
            k0  <= k1;
            k1  <= k2;
            k2  <= k3;
            k3  <= rk;
            rnd <= rnd + 5'd1;
            if (last_round) kv_q <= 1'b1;
         end
      end
   end

   sm4_rk_regfile u_rf (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (in_round),
      .waddr  (rnd),
      .wdata  (rk),
      .raddr  (rk_rd_addr),
`ifdef SM4_KEY_DEC_ORDER_EN
      .rd_rev (rk_dec),
`endif
      .rdata  (rd_raw)
   );

   assign rk_rd_data = key_valid ? rd_raw : '0;

endmodule

// File: tb/tb_sm4_key_sched.sv
// Directed bench for sm4_key_sched, ROM_LAT 1 and 2 side by side.
module tb_sm4_key_sched;

   localparam logic [7:0] SBOX [256] = '{
      8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
      8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
      8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
      8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
      8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
      8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
      8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
      8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
      8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
      8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
      8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
      8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
      8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
      8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
      8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
      8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
   };

   localparam logic [127:0] KEY_A = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY_C = 128'hdeadbeef0badf00dcafebabe13572468;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] rk;
   } vec_t;

   logic         clk, rst_n, start;
   logic [127:0] mk;
   logic [4:0]   addr;
   logic [4:0]   ck_count1, ck_count2;
   logic [31:0]  ck_data1, ck_data2, t_in1, t_in2, t_out1, t_out2;
   logic [31:0]  rd1, rd2, r1a, r2a, r2b;
   logic         busy1, busy2, done1, done2, kv1, kv2;
`ifdef SM4_KEY_DEC_ORDER_EN
   logic         rk_dec;
`endif
   logic [31:0]  exp_rk [32];
   int           total, bad;

   function automatic logic [31:0] ck_word(input int n);
      logic [31:0] w;
      for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'(((4*n + j) * 7) % 256);
      return w;
   endfunction

   function automatic logic [31:0] tprime(input logic [31:0] x);
      logic [31:0] b;
      b = {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
      return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
   endfunction

   sm4_key_sched #(.ROM_LAT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .mk(mk),
      .ck_count(ck_count1), .ck_data(ck_data1),
      .t_in(t_in1), .t_out(t_out1),
      .busy(busy1), .done(done1), .key_valid(kv1),
      .rk_rd_addr(addr),
`ifdef SM4_KEY_DEC_ORDER_EN
      .rk_dec(rk_dec),
`endif
      .rk_rd_data(rd1)
   );

   sm4_key_sched #(.ROM_LAT(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .mk(mk),
      .ck_count(ck_count2), .ck_data(ck_data2),
      .t_in(t_in2), .t_out(t_out2),
      .busy(busy2), .done(done2), .key_valid(kv2),
      .rk_rd_addr(addr),
`ifdef SM4_KEY_DEC_ORDER_EN
      .rk_dec(rk_dec),
`endif
      .rk_rd_data(rd2)
   );

   assign t_out1 = tprime(t_in1);
   assign t_out2 = tprime(t_in2);

   always @(posedge clk) begin
      r1a <= ck_word(int'(ck_count1));
      r2a <= ck_word(int'(ck_count2));
      r2b <= r2a;
   end
   assign ck_data1 = r1a;
   assign ck_data2 = r2b;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic build_model(input logic [127:0] key);
      logic [31:0] k [4];
      k[0] = key[127:96] ^ 32'ha3b1bac6;
      k[1] = key[95:64]  ^ 32'h56aa3350;
      k[2] = key[63:32]  ^ 32'h677d9197;
      k[3] = key[31:0]   ^ 32'hb27022dc;
      for (int i = 0; i < 32; i++) begin
         exp_rk[i] = k[0] ^ tprime(k[1] ^ k[2] ^ k[3] ^ ck_word(i));
         k[0] = k[1];
         k[1] = k[2];
         k[2] = k[3];
         k[3] = exp_rk[i];
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " busy1"}, 32'(busy1), 0);
      chk({tag, " busy2"}, 32'(busy2), 0);
      chk({tag, " done1"}, 32'(done1), 0);
      chk({tag, " done2"}, 32'(done2), 0);
      chk({tag, " kv1"}, 32'(kv1), 0);
      chk({tag, " kv2"}, 32'(kv2), 0);
      chk({tag, " ck1"}, 32'(ck_count1), 0);
      chk({tag, " ck2"}, 32'(ck_count2), 0);
      chk({tag, " tin1"}, t_in1, 0);
      chk({tag, " tin2"}, t_in2, 0);
      chk({tag, " rd1"}, rd1, 0);
      chk({tag, " rd2"}, rd2, 0);
   endtask

   task automatic check_store(input string tag);
      for (int i = 0; i < 32; i++) begin
         addr = 5'(i);
         #1;
         chk($sformatf("%s rd1[%0d]", tag, i), rd1, exp_rk[i]);
         chk($sformatf("%s rd2[%0d]", tag, i), rd2, exp_rk[i]);
      end
      addr = '0;
   endtask

   task automatic run_key(input logic [127:0] key);
      int c;
      mk = key;
      start = 1'b1;
      tick();
      start = 1'b0;
      c = 1;
      while (!done2 && c < 60) begin
         tick();
         c++;
      end
      chk("run timeout", 32'(done2), 1);
      tick();
   endtask

   initial begin
      vec_t vt [3];
      int   dn;
      total = 0;
      bad   = 0;
      vt[0] = '{5'd0,  32'hf12186f9};
      vt[1] = '{5'd1,  32'h41662b61};
      vt[2] = '{5'd31, 32'h9124a012};
      start = 1'b0;
      mk    = '0;
      addr  = '0;
`ifdef SM4_KEY_DEC_ORDER_EN
      rk_dec = 1'b0;
`endif
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      tick();
      tick();
      check_zero("reset");
      rst_n = 1'b1;
      tick();

      // start pulse at cycle 0; cycle-exact waveform for both latencies
      mk = KEY_A;
      start = 1'b1;
      for (int c = 1; c <= 45; c++) begin
         tick();
         start = 1'b0;
         chk($sformatf("c%0d ck1", c), 32'(ck_count1),
             (c >= 1 && c <= 33) ? 32'((c - 1) % 32) : 0);
         chk($sformatf("c%0d ck2", c), 32'(ck_count2),
             (c >= 1 && c <= 34) ? 32'((c - 1) % 32) : 0);
         chk($sformatf("c%0d busy1", c), 32'(busy1), 32'(c >= 1 && c <= 33));
         chk($sformatf("c%0d busy2", c), 32'(busy2), 32'(c >= 1 && c <= 34));
         chk($sformatf("c%0d done1", c), 32'(done1), 32'(c == 34));
         chk($sformatf("c%0d done2", c), 32'(done2), 32'(c == 35));
         chk($sformatf("c%0d kv1", c), 32'(kv1), 32'(c >= 34));
         chk($sformatf("c%0d kv2", c), 32'(kv2), 32'(c >= 35));
         if (!(c >= 2 && c <= 33)) chk($sformatf("c%0d tin1", c), t_in1, 0);
         if (!(c >= 3 && c <= 34)) chk($sformatf("c%0d tin2", c), t_in2, 0);
      end

      for (int i = 0; i < 3; i++) begin
         addr = vt[i].addr;
         #1;
         chk($sformatf("vecA1 a%0d", vt[i].addr), rd1, vt[i].rk);
         chk($sformatf("vecA2 a%0d", vt[i].addr), rd2, vt[i].rk);
      end
      build_model(KEY_A);
      check_store("keyA");

`ifdef SM4_KEY_DEC_ORDER_EN
      rk_dec = 1'b1;
      addr = 5'd0;
      #1 chk("dec a0", rd1, 32'h9124a012);
      addr = 5'd31;
      #1 chk("dec a31", rd1, 32'hf12186f9);
      rk_dec = 1'b0;
      addr = 5'd0;
`endif

      // start held high: one expansion, re-accepted only from IDLE
      mk = KEY_B;
      start = 1'b1;
      dn = 0;
      for (int c = 1; c <= 36; c++) begin
         tick();
         if (c <= 35 && done1) dn++;
         if (c == 34) chk("held kv1 done", 32'(kv1), 1);
         if (c == 35) begin
            chk("held busy1 idle", 32'(busy1), 0);
            chk("held kv1 drop", 32'(kv1), 0);
            chk("held rd1 gated", rd1, 0);
         end
         if (c == 36) chk("held busy1 again", 32'(busy1), 1);
      end
      chk("held done count", 32'(dn), 1);
      start = 1'b0;
      for (int c = 0; c < 60 && !(kv1 && kv2 && !busy1 && !busy2); c++) tick();
      chk("held finish", 32'(kv1 && kv2), 1);
      build_model(KEY_B);
      check_store("keyB");

      // reset in the middle of ROUND 15
      mk = KEY_C;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 2; c <= 17; c++) tick();
      chk("pre-reset busy1", 32'(busy1), 1);
      chk("pre-reset ck1", 32'(ck_count1), 16);
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      tick();
      rst_n = 1'b1;
      tick();
      run_key(KEY_C);
      build_model(KEY_C);
      check_store("keyC");
      run_key(KEY_A);
      addr = 5'd31;
      #1 chk("rerun a31", rd1, 32'h9124a012);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
